// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_ZERO          : hard-wired zero register, never a hazard source
//   MDU_CLASS_*       : values of ex_mdu_is_div selecting the op class
//   mdu_state_e       : MDU busy-tracker FSM encoding
//   reg_hit()         : true when a producer register feeds a consumer operand
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic MDU_CLASS_MUL = 1'b0;
    localparam logic MDU_CLASS_DIV = 1'b1;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Register 0 is constant, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_tracker.sv
// Tracks the multi-cycle multiply/divide unit occupancy.
//   clk, reset : core clock, synchronous active-high reset
//   start      : MDU op issued in EX this cycle (ignored while busy)
//   is_div     : qualifies start, selects divide vs multiply latency
//   busy       : an MDU op is in flight
//   last       : final busy cycle; the MDU frees at the next edge
module mdu_busy_tracker
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic last
);

    localparam int unsigned MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned REM_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state_q, state_d;
    logic [REM_W-1:0] remaining_q, remaining_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MDU_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Next state: the issue cycle itself counts as the first EX cycle,
    // so the down counter is loaded with latency-1.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    state_d     = MDU_BUSY;
                    remaining_d = (is_div == MDU_CLASS_DIV) ? REM_W'(DIV_CYCLES - 1)
                                                            : REM_W'(MULT_CYCLES - 1);
                end
            end
            MDU_BUSY: begin
                remaining_d = remaining_q - REM_W'(1);
                if (remaining_q == REM_W'(1)) begin
                    state_d = MDU_IDLE;
                end
            end
            default: begin
                state_d     = MDU_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == MDU_BUSY);
        last = (state_q == MDU_BUSY) && (remaining_q == REM_W'(1));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage core: drives pipeline-register
// enables/flushes and owns the MDU busy tracker and a stall counter.
//   inputs : ID operand info, EX/MEM producer info, MDU issue, exc_flush
//   pc_en, if_id_en                         : 0 = hold stage
//   if_id_flush, id_ex_flush, ex_mem_flush  : insert bubble
//   mdu_busy                                : MDU op in flight
//   stall_count                             : saturating count of stall cycles
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_is_mdu,
    input  logic             id_br_taken,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_dst,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_dst,
    input  logic             ex_mdu_start,
    input  logic             ex_mdu_is_div,
    input  logic             exc_flush,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    logic             mdu_last;
    logic             lu, brx, brm, mdh, stall;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    mdu_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_busy_tracker (
        .clk    (clk),
        .reset  (reset),
        .start  (ex_mdu_start),
        .is_div (ex_mdu_is_div),
        .busy   (mdu_busy),
        .last   (mdu_last)
    );

    // Hazard detection; exception redirect overrides every stall.
    always_comb begin
        lu    = ex_mem_read &
                (reg_hit(ex_dst, id_rs) | (id_uses_rt & reg_hit(ex_dst, id_rt)));
        brx   = id_is_branch & ex_reg_write &
                (reg_hit(ex_dst, id_rs) | reg_hit(ex_dst, id_rt));
        brm   = id_is_branch & mem_mem_read &
                (reg_hit(mem_dst, id_rs) | reg_hit(mem_dst, id_rt));
        // The final busy cycle already releases ID.
        mdh   = id_is_mdu & ((mdu_busy & ~mdu_last) | ex_mdu_start);
        stall = (lu | brx | brm | mdh) & ~exc_flush;
    end

    // Pipeline control; a taken branch is re-resolved once the stall clears.
    always_comb begin
        pc_en        = ~stall;
        if_id_en     = ~stall;
        id_ex_flush  = stall | exc_flush;
        if_id_flush  = exc_flush | (id_br_taken & ~stall);
        ex_mem_flush = exc_flush;
    end

    // Saturating stall counter
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
